// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs and ID/EX register outputs of the ID/EX stage
interface id_ex_stage_if #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 8
);
   logic              id_valid;
   logic [XLEN-1:0]   id_pc;
   logic [4:0]        id_rs1;
   logic [4:0]        id_rs2;
   logic [4:0]        id_rd;
   logic              id_uses_rs2;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic [3:0]        id_funct;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;
   logic [CTRL_W-1:0] id_ctrl;
   logic              ex_flush;

   logic              stall;
   logic              ID_EX_valid;
   logic [XLEN-1:0]   ID_EX_PC;
   logic [XLEN-1:0]   ID_EX_Rs1Data;
   logic [XLEN-1:0]   ID_EX_Rs2Data;
   logic [XLEN-1:0]   ID_EX_Imm;
   logic [4:0]        ID_EX_Rs1;
   logic [4:0]        ID_EX_Rs2;
   logic [4:0]        ID_EX_Rd;
   logic [3:0]        ID_EX_Funct;
   logic              ID_EX_RegWrite;
   logic              ID_EX_MemRead;
   logic              ID_EX_MemWrite;
   logic [CTRL_W-1:0] ID_EX_Ctrl;

   modport master (
      output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs2, id_rs1_data,
             id_rs2_data, id_imm, id_funct, id_reg_write, id_mem_read,
             id_mem_write, id_ctrl, ex_flush,
      input  stall, ID_EX_valid, ID_EX_PC, ID_EX_Rs1Data, ID_EX_Rs2Data,
             ID_EX_Imm, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_Funct,
             ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Ctrl
   );

   modport slave (
      input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_uses_rs2, id_rs1_data,
             id_rs2_data, id_imm, id_funct, id_reg_write, id_mem_read,
             id_mem_write, id_ctrl, ex_flush,
      output stall, ID_EX_valid, ID_EX_PC, ID_EX_Rs1Data, ID_EX_Rs2Data,
             ID_EX_Imm, ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_Funct,
             ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Ctrl
   );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush bubbles
// Optional macro HAZARD_STATS_EN adds saturating stall_count/flush_count outputs.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   id_ex_stage_if.slave bus
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
`endif
);

   logic              r_valid;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_rs1_data;
   logic [XLEN-1:0]   r_rs2_data;
   logic [XLEN-1:0]   r_imm;
   logic [4:0]        r_rs1;
   logic [4:0]        r_rs2;
   logic [4:0]        r_rd;
   logic [3:0]        r_funct;
   logic              r_reg_write;
   logic              r_mem_read;
   logic              r_mem_write;
   logic [CTRL_W-1:0] r_ctrl;

   logic w_hazard;
   logic w_stall;
   logic w_bubble;
   logic w_live;

   // The load in EX cannot forward in time to the instruction now in ID.
   assign w_hazard = r_valid & r_mem_read & (r_rd != 5'd0) & bus.id_valid &
                     ((r_rd == bus.id_rs1) | (bus.id_uses_rs2 & (r_rd == bus.id_rs2)));
   assign w_stall  = rst_n & w_hazard & ~bus.ex_flush;
   assign w_bubble = bus.ex_flush | w_stall;
   assign w_live   = bus.id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_funct     <= '0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_ctrl      <= '0;
      end else if (w_bubble) begin
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_funct     <= '0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_ctrl      <= '0;
      end else begin
         r_valid     <= w_live;
         r_pc        <= bus.id_pc;
         r_rs1_data  <= bus.id_rs1_data;
         r_rs2_data  <= bus.id_rs2_data;
         r_imm       <= bus.id_imm;
         r_rs1       <= bus.id_rs1;
         r_rs2       <= bus.id_rs2;
         r_rd        <= bus.id_rd;
         r_funct     <= bus.id_funct;
         // An empty slot must never write the register file or touch memory.
         r_reg_write <= w_live & bus.id_reg_write;
         r_mem_read  <= w_live & bus.id_mem_read;
         r_mem_write <= w_live & bus.id_mem_write;
         r_ctrl      <= w_live ? bus.id_ctrl : '0;
      end
   end

   assign bus.stall          = w_stall;
   assign bus.ID_EX_valid    = r_valid;
   assign bus.ID_EX_PC       = r_pc;
   assign bus.ID_EX_Rs1Data  = r_rs1_data;
   assign bus.ID_EX_Rs2Data  = r_rs2_data;
   assign bus.ID_EX_Imm      = r_imm;
   assign bus.ID_EX_Rs1      = r_rs1;
   assign bus.ID_EX_Rs2      = r_rs2;
   assign bus.ID_EX_Rd       = r_rd;
   assign bus.ID_EX_Funct    = r_funct;
   assign bus.ID_EX_RegWrite = r_reg_write;
   assign bus.ID_EX_MemRead  = r_mem_read;
   assign bus.ID_EX_MemWrite = r_mem_write;
   assign bus.ID_EX_Ctrl     = r_ctrl;

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_count;
   logic [31:0] r_flush_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_stall && (r_stall_count != 32'hFFFF_FFFF))
            r_stall_count <= r_stall_count + 32'd1;
         if (bus.ex_flush && (r_flush_count != 32'hFFFF_FFFF))
            r_flush_count <= r_flush_count + 32'd1;
      end
   end

   assign stall_count = r_stall_count;
   assign flush_count = r_flush_count;
`endif

endmodule
